axis_frame_arbiter: RTL

AXIS_FRAME_ARBITER -- requirements
Module: axis_frame_arbiter

---
 rtl/axis_frame_arb_pkg.sv | 21 ++
 rtl/axis_rr_arbiter.sv | 48 ++++
 rtl/axis_frame_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/axis_frame_arb_pkg.sv
// ---------------------------------------------------------------------------
// axis_frame_arb_pkg
//
// Shared definitions for the AXI-Stream frame arbiter slice:
//   - arb_state_e : two-state frame arbiter FSM encoding (IDLE / XFER)
//   - idx_width() : width of a port index for a given port count, never
//                   narrower than one bit so a 1-bit index still exists
//                   even for degenerate port counts.
// ---------------------------------------------------------------------------
package axis_frame_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_rr_arbiter.sv
// ---------------------------------------------------------------------------
// axis_rr_arbiter
//
// Purely combinational round-robin picker. Starting one position above the
// previous winner and wrapping modulo S_COUNT, it returns the first port
// whose request bit is set.
//
// Ports:
//   req        [S_COUNT-1:0] in  : request vector (one bit per port)
//   last_grant [IDX_W-1:0]   in  : index of the most recent winner
//   grant_oh   [S_COUNT-1:0] out : one-hot pick (all zero when nothing found)
//   grant_idx  [IDX_W-1:0]   out : encoded pick (zero when nothing found)
//   found                    out : at least one request was present
// ---------------------------------------------------------------------------
module axis_rr_arbiter #(
  parameter int S_COUNT = 4,
  parameter int IDX_W   = 2
) (
  input  logic [S_COUNT-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [S_COUNT-1:0] grant_oh,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               found
);

  int cand;

  // Walk the ports in rotated order (last_grant+1 first, last_grant itself
  // last). The inner loop compares against a constant index so every
  // selection stays a fixed bit select once the loops are unrolled.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 1; k <= S_COUNT; k++) begin
      cand = (int'(last_grant) + k) % S_COUNT;
      for (int i = 0; i < S_COUNT; i++) begin
        if (!found && (cand == i) && req[i]) begin
          found       = 1'b1;
          grant_oh[i] = 1'b1;
          grant_idx   = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/axis_frame_arbiter.sv
// ---------------------------------------------------------------------------
// axis_frame_arbiter
//
// Frame-granular round-robin arbiter merging S_COUNT AXI-Stream inputs onto
// one output. Once a port wins it owns the output until a beat carrying
// tlast is accepted; the output then spends one IDLE cycle before the next
// grant is issued. In IDLE every output data field is forced to zero.
//
// Optional feature macro: AXIS_FRAME_ARB_TID_EN
//   When defined, an extra output m_axis_tid carries the owning port index
//   during a transfer (zero in IDLE).
//
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   s_axis_t{data,keep,user}   : packed per-port payload, port i at slice i
//   s_axis_t{valid,last}       : per-port valid / end-of-frame
//   s_axis_tready              : per-port ready, only the owner's bit moves
//   m_axis_t{data,keep,user,valid,last} : merged output stream
//   m_axis_tid                 : owner index (AXIS_FRAME_ARB_TID_EN only)
//   m_axis_tready              : downstream ready
//   grant_valid                : a port currently owns the output
//   grant_idx                  : index of the owning port
// ---------------------------------------------------------------------------
module axis_frame_arbiter
  import axis_frame_arb_pkg::*;
#(
  parameter int S_COUNT    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = 1,
  parameter int USER_WIDTH = 1,
  localparam int IDX_W     = idx_width(S_COUNT)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  output logic [S_COUNT-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
`ifdef AXIS_FRAME_ARB_TID_EN
  output logic [IDX_W-1:0]              m_axis_tid,
`endif
  input  logic                          m_axis_tready,
  output logic                          grant_valid,
  output logic [IDX_W-1:0]              grant_idx
);

  arb_state_e          state;
  logic [IDX_W-1:0]    last_grant;
  logic [S_COUNT-1:0]  grant_oh;
  logic [S_COUNT-1:0]  active_oh;
  logic [S_COUNT-1:0]  pick_oh;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_found;
  logic                xfer;
  logic                frame_done;

  axis_rr_arbiter #(
    .S_COUNT (S_COUNT),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req        (s_axis_tvalid),
    .last_grant (last_grant),
    .grant_oh   (pick_oh),
    .grant_idx  (pick_idx),
    .found      (pick_found)
  );

  assign xfer        = (state == XFER);
  assign grant_valid = xfer;

  // grant_oh keeps its last value after a frame ends, so it is masked with
  // the state; that single mask is what zeroes every output field in IDLE.
  assign active_oh     = xfer ? grant_oh : '0;
  assign s_axis_tready = active_oh & {S_COUNT{m_axis_tready}};

  // One-hot AND-OR mux of the owner's slice onto the shared output.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tuser  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (active_oh[i]) begin
        m_axis_tdata  = m_axis_tdata  | s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        m_axis_tkeep  = m_axis_tkeep  | s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        m_axis_tuser  = m_axis_tuser  | s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
        m_axis_tvalid = m_axis_tvalid | s_axis_tvalid[i];
        m_axis_tlast  = m_axis_tlast  | s_axis_tlast[i];
      end
    end
  end

`ifdef AXIS_FRAME_ARB_TID_EN
  assign m_axis_tid = xfer ? grant_idx : '0;
`endif

  // The last beat of a frame is the only event that releases ownership.
  assign frame_done = xfer & m_axis_tvalid & m_axis_tready & m_axis_tlast;

  // Reset forces last_grant to the top port so that port 0 is searched
  // first. A grant is taken only from IDLE, which is what guarantees the
  // single bubble cycle between back-to-back frames.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= IDX_W'(S_COUNT - 1);
      grant_idx  <= '0;
      grant_oh   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state      <= XFER;
            grant_idx  <= pick_idx;
            last_grant <= pick_idx;
            grant_oh   <= pick_oh;
          end
        end
        XFER: begin
          if (frame_done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
